// File: rtl/lcd_pkg.sv
// lcd_pkg
// Shared definitions for the HD44780 8-bit power-on init monitor:
// default timing constants (cycles at 50 MHz), the function-set data
// values, the monitor FSM state encoding and the violation codes.
`timescale 1ns/1ps
package lcd_pkg;

    localparam int unsigned T_PWR = 750000;
    localparam int unsigned T_W2  = 205000;
    localparam int unsigned T_W3  = 5000;
    localparam int unsigned T_W4  = 2000;
    localparam int unsigned E_MIN = 12;

    localparam logic [7:0] LCD_FSET_8B = 8'h3F;
    localparam logic [7:0] LCD_FSET_4B = 8'h2F;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_GAP  = 3'd1,
        ST_HIGH = 3'd2,
        ST_OK   = 3'd3,
        ST_ERR  = 3'd4
    } state_t;

    typedef enum logic [2:0] {
        ERR_NONE   = 3'd0,
        ERR_GAP    = 3'd1,
        ERR_PULSE  = 3'd2,
        ERR_DATA   = 3'd3,
        ERR_CHANGE = 3'd4
    } err_t;

    // The first three writes select 8-bit mode, the fourth drops to 4-bit.
    function automatic logic [7:0] expected_data(input logic [2:0] idx);
        return (idx == 3'd3) ? LCD_FSET_4B : LCD_FSET_8B;
    endfunction

endpackage

// File: rtl/lcd_init_monitor_sat_counter.sv
// sat_counter
// Up-counter that sticks at all-ones instead of wrapping.
// Ports:
//   clk, reset  clock, asynchronous active-high reset
//   clr         restart the count; the current cycle is still counted if en
//   en          count this cycle
//   q           current count
`timescale 1ns/1ps
module sat_counter #(
    parameter int unsigned CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clr,
    input  logic             en,
    output logic [CNT_W-1:0] q
);

    localparam logic [CNT_W-1:0] ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [CNT_W-1:0] q_q;
    logic [CNT_W-1:0] q_d;

    // A clear restarts at 0 but still counts the clearing cycle when
    // enabled, so a counter cleared on an edge includes that edge's sample.
    always_comb begin
        q_d = q_q;
        if (clr) begin
            q_d = en ? ONE : '0;
        end else if (en && (q_q != '1)) begin
            q_d = q_q + ONE;
        end
    end

    // Count register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            q_q <= '0;
        end else begin
            q_q <= q_d;
        end
    end

    assign q = q_q;

endmodule

// File: rtl/lcd_init_monitor.sv
// lcd_init_monitor
// LCD-side checker for the HD44780 8-bit power-on init sequence. Samples
// lcd_e/lcd_db like the display, checks the four function-set writes, the
// enable pulse widths and the waits between them, then reports pass or
// the first violation.
// Ports:
//   clk, reset   clock, asynchronous active-high reset
//   arm_i        one-cycle start; restarts the check from any state
//   lcd_e_i      LCD enable from the init driver
//   lcd_db_i     LCD data bus
//   busy_o       check in progress
//   init_ok_o    sticky pass flag
//   init_err_o   sticky fail flag
//   err_code_o   first violation (see lcd_pkg::err_t)
//   wr_count_o   accepted writes, 0..4
`timescale 1ns/1ps
module lcd_init_monitor #(
    parameter int unsigned T_PWR = lcd_pkg::T_PWR,
    parameter int unsigned T_W2  = lcd_pkg::T_W2,
    parameter int unsigned T_W3  = lcd_pkg::T_W3,
    parameter int unsigned T_W4  = lcd_pkg::T_W4,
    parameter int unsigned E_MIN = lcd_pkg::E_MIN,
    parameter int unsigned CNT_W = 32
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       arm_i,
    input  logic       lcd_e_i,
    input  logic [7:0] lcd_db_i,
    output logic       busy_o,
    output logic       init_ok_o,
    output logic       init_err_o,
    output logic [2:0] err_code_o,
    output logic [2:0] wr_count_o
);

    import lcd_pkg::*;

    state_t           state_q, state_d;
    logic             e_q;
    logic [7:0]       db_lat_q;
    logic [2:0]       wr_count_q, wr_count_d;
    logic [2:0]       err_code_q, err_code_d;
    logic             busy_q, busy_d;
    logic             init_ok_q, init_ok_d;
    logic             init_err_q, init_err_d;
    logic             rise, fall;
    logic [CNT_W-1:0] gap_cnt_q;
    logic [CNT_W-1:0] hi_cnt_q;
    logic [CNT_W-1:0] gap_req;

    assign rise = lcd_e_i & ~e_q;
    assign fall = ~lcd_e_i & e_q;

    sat_counter #(.CNT_W(CNT_W)) u_gap_cnt (
        .clk   (clk),
        .reset (reset),
        .clr   (arm_i | fall),
        .en    (~lcd_e_i),
        .q     (gap_cnt_q)
    );

    sat_counter #(.CNT_W(CNT_W)) u_hi_cnt (
        .clk   (clk),
        .reset (reset),
        .clr   (rise),
        .en    (lcd_e_i),
        .q     (hi_cnt_q)
    );

    // Minimum low time owed before the pending write.
    always_comb begin
        case (wr_count_q)
            3'd0:    gap_req = CNT_W'(T_PWR);
            3'd1:    gap_req = CNT_W'(T_W2);
            3'd2:    gap_req = CNT_W'(T_W3);
            default: gap_req = CNT_W'(T_W4);
        endcase
    end

    // Next-state logic. arm overrides every check; at a fall the short
    // pulse test comes before the data test so the lower code wins.
    // The registered flags are decoded from the next state so they move
    // together with the state register.
    always_comb begin
        state_d    = state_q;
        wr_count_d = wr_count_q;
        err_code_d = err_code_q;
        if (arm_i) begin
            state_d    = ST_GAP;
            wr_count_d = 3'd0;
            err_code_d = ERR_NONE;
        end else begin
            case (state_q)
                ST_GAP: begin
                    if (wr_count_q == 3'd4) begin
                        if (rise) begin
                            state_d    = ST_ERR;
                            err_code_d = ERR_GAP;
                        end else if (gap_cnt_q >= CNT_W'(T_W4)) begin
                            state_d = ST_OK;
                        end
                    end else if (rise) begin
                        if (gap_cnt_q < gap_req) begin
                            state_d    = ST_ERR;
                            err_code_d = ERR_GAP;
                        end else begin
                            state_d = ST_HIGH;
                        end
                    end
                end
                ST_HIGH: begin
                    if (lcd_e_i && (lcd_db_i != db_lat_q)) begin
                        state_d    = ST_ERR;
                        err_code_d = ERR_CHANGE;
                    end else if (fall) begin
                        if (hi_cnt_q < CNT_W'(E_MIN)) begin
                            state_d    = ST_ERR;
                            err_code_d = ERR_PULSE;
                        end else if (db_lat_q != expected_data(wr_count_q)) begin
                            state_d    = ST_ERR;
                            err_code_d = ERR_DATA;
                        end else begin
                            state_d    = ST_GAP;
                            wr_count_d = wr_count_q + 3'd1;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
        busy_d     = (state_d == ST_GAP) || (state_d == ST_HIGH);
        init_ok_d  = (state_d == ST_OK);
        init_err_d = (state_d == ST_ERR);
    end

    // State, edge history, data latch and output registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            e_q        <= 1'b0;
            db_lat_q   <= 8'h00;
            wr_count_q <= 3'd0;
            err_code_q <= 3'd0;
            busy_q     <= 1'b0;
            init_ok_q  <= 1'b0;
            init_err_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            e_q        <= lcd_e_i;
            if (rise) begin
                db_lat_q <= lcd_db_i;
            end
            wr_count_q <= wr_count_d;
            err_code_q <= err_code_d;
            busy_q     <= busy_d;
            init_ok_q  <= init_ok_d;
            init_err_q <= init_err_d;
        end
    end

    assign busy_o     = busy_q;
    assign init_ok_o  = init_ok_q;
    assign init_err_o = init_err_q;
    assign err_code_o = err_code_q;
    assign wr_count_o = wr_count_q;

endmodule

// File: tb/tb_lcd_init_monitor.sv
// tb_lcd_init_monitor
// Drives init sequences described as lists of writes (gap, pulse width,
// data, optional mid-pulse data change) and compares the monitor's
// verdict, its timing and the write count with a reference computed
// directly from the write list.
`timescale 1ns/1ps
module tb_lcd_init_monitor;

    localparam int TB_T_PWR = 100;
    localparam int TB_T_W2  = 40;
    localparam int TB_T_W3  = 10;
    localparam int TB_T_W4  = 5;
    localparam int TB_E_MIN = 3;

    logic       clk = 1'b0;
    logic       reset;
    logic       arm;
    logic       lcd_e;
    logic [7:0] lcd_db;
    logic       busy;
    logic       init_ok;
    logic       init_err;
    logic [2:0] err_code;
    logic [2:0] wr_count;

    int vectors     = 0;
    int miscompares = 0;

    int         gapA    [6];
    int         widthA  [6];
    int         toggleA [6];
    logic [7:0] dataA   [6];
    int         nPulses;

    int expObs;
    int expOk;
    int expCode;
    int expWr;

    always #5 clk = ~clk;

    // Counters are 8 bits wide so a 300-cycle power-on gap saturates.
    lcd_init_monitor #(
        .T_PWR (TB_T_PWR),
        .T_W2  (TB_T_W2),
        .T_W3  (TB_T_W3),
        .T_W4  (TB_T_W4),
        .E_MIN (TB_E_MIN),
        .CNT_W (8)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .arm_i      (arm),
        .lcd_e_i    (lcd_e),
        .lcd_db_i   (lcd_db),
        .busy_o     (busy),
        .init_ok_o  (init_ok),
        .init_err_o (init_err),
        .err_code_o (err_code),
        .wr_count_o (wr_count)
    );

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        vectors++;
        if (observed !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: observed %0d, expected %0d", tag, observed, expected);
        end
    endtask

    function automatic int reqOf(input int w);
        case (w)
            0:       return TB_T_PWR;
            1:       return TB_T_W2;
            2:       return TB_T_W3;
            default: return TB_T_W4;
        endcase
    endfunction

    function automatic logic [7:0] tableOf(input int w);
        return (w == 3) ? 8'h2F : 8'h3F;
    endfunction

    task automatic setPulse(input int i, input int g, input int w, input logic [7:0] d,
                            input int t);
        gapA[i]    = g;
        widthA[i]  = w;
        dataA[i]   = d;
        toggleA[i] = t;
    endtask

    // Reference: walk the write list in absolute cycles (arm = cycle 0,
    // itself a low cycle) and find the first event; the flag is visible
    // the cycle after the sample that decides it.
    task automatic predict();
        int w;
        int t;
        int r;
        int f;
        w = 0;
        t = 0;
        expObs = -1;
        expOk = 0;
        expCode = 0;
        for (int i = 0; i < nPulses; i++) begin
            r = t + gapA[i];
            if (w == 4) begin
                if (gapA[i] > TB_T_W4) begin
                    expOk = 1; expObs = t + TB_T_W4 + 1;
                end else begin
                    expCode = 1; expObs = r + 1;
                end
                expWr = w;
                return;
            end
            if (gapA[i] < reqOf(w)) begin
                expCode = 1; expObs = r + 1; expWr = w;
                return;
            end
            if (toggleA[i] > 0 && toggleA[i] < widthA[i]) begin
                expCode = 4; expObs = r + toggleA[i] + 1; expWr = w;
                return;
            end
            f = r + widthA[i];
            if (widthA[i] < TB_E_MIN) begin
                expCode = 2; expObs = f + 1; expWr = w;
                return;
            end
            if (dataA[i] != tableOf(w)) begin
                expCode = 3; expObs = f + 1; expWr = w;
                return;
            end
            w++;
            t = f;
        end
        expWr = w;
        if (w == 4) begin
            expOk = 1;
            expObs = t + TB_T_W4 + 1;
        end
    endtask

    // Expand the write list into a per-cycle waveform, play it after an
    // arm and compare the verdict. Data is held through the first low
    // cycle after each pulse and is random elsewhere in the gaps.
    task automatic applyStimulus(input string name);
        int         eQ[$];
        logic [7:0] dbQ[$];
        logic [7:0] cur;
        int         seen;
        int         len;
        predict();
        cur = 8'($urandom);
        for (int i = 0; i < nPulses; i++) begin
            for (int j = 0; j < gapA[i]; j++) begin
                if (j != 0) cur = 8'($urandom);
                eQ.push_back(0);
                dbQ.push_back(cur);
            end
            cur = dataA[i];
            for (int j = 0; j < widthA[i]; j++) begin
                if (toggleA[i] > 0 && j == toggleA[i]) cur = cur ^ 8'h10;
                eQ.push_back(1);
                dbQ.push_back(cur);
            end
        end
        for (int j = 0; j < TB_T_W4 + 3; j++) begin
            if (j != 0) cur = 8'($urandom);
            eQ.push_back(0);
            dbQ.push_back(cur);
        end
        len = eQ.size();
        seen = -1;
        for (int c = 0; c < len + 4; c++) begin
            @(negedge clk);
            if (c == 1) checkOutput({name, " busy after arm"}, 32'(busy), 32'd1);
            if (c >= 1 && seen < 0 && (init_ok || init_err)) seen = c;
            arm   = (c == 0);
            lcd_e = (c < len) ? (eQ[c] != 0) : 1'b0;
            if (c < len) lcd_db = dbQ[c];
        end
        @(negedge clk);
        arm = 1'b0;
        checkOutput({name, " verdict cycle"}, 32'(seen), 32'(expObs));
        checkOutput({name, " init_ok"}, 32'(init_ok), 32'(expOk));
        checkOutput({name, " init_err"}, 32'(init_err), 32'(expOk == 0));
        checkOutput({name, " err_code"}, 32'(err_code), 32'(expCode));
        checkOutput({name, " wr_count"}, 32'(wr_count), 32'(expWr));
        checkOutput({name, " busy done"}, 32'(busy), 32'd0);
    endtask

    task automatic setNominal();
        nPulses = 4;
        setPulse(0, TB_T_PWR, TB_E_MIN, 8'h3F, 0);
        setPulse(1, TB_T_W2,  TB_E_MIN, 8'h3F, 0);
        setPulse(2, TB_T_W3,  TB_E_MIN, 8'h3F, 0);
        setPulse(3, TB_T_W4,  TB_E_MIN, 8'h2F, 0);
    endtask

    initial begin
        int mode;
        reset  = 1'b1;
        arm    = 1'b0;
        lcd_e  = 1'b0;
        lcd_db = 8'h00;
        repeat (2) @(negedge clk);
        checkOutput("reset busy", 32'(busy), 32'd0);
        checkOutput("reset flags", 32'({init_ok, init_err}), 32'd0);
        checkOutput("reset err_code", 32'(err_code), 32'd0);
        checkOutput("reset wr_count", 32'(wr_count), 32'd0);
        reset = 1'b0;
        repeat (2) @(negedge clk);

        setNominal();
        applyStimulus("nominal");

        setNominal();
        gapA[0] = TB_T_PWR - 1;
        applyStimulus("gap99");

        setNominal();
        widthA[1] = TB_E_MIN - 1;
        applyStimulus("short pulse2");

        setNominal();
        dataA[3] = 8'h3F;
        applyStimulus("bad data4");

        setNominal();
        toggleA[0] = 1;
        applyStimulus("toggle w1");

        setNominal();
        nPulses = 5;
        setPulse(4, 2, TB_E_MIN, 8'h3F, 0);
        applyStimulus("extra rise");

        setNominal();
        gapA[0] = 300;
        applyStimulus("saturated gap");

        // Reset in the middle of the second gap, then a clean rerun.
        @(negedge clk);
        arm = 1'b1;
        lcd_e = 1'b0;
        @(negedge clk);
        arm = 1'b0;
        repeat (TB_T_PWR - 1) @(negedge clk);
        lcd_e  = 1'b1;
        lcd_db = 8'h3F;
        repeat (TB_E_MIN) @(negedge clk);
        lcd_e = 1'b0;
        repeat (20) @(negedge clk);
        checkOutput("mid wr_count", 32'(wr_count), 32'd1);
        checkOutput("mid busy", 32'(busy), 32'd1);
        reset = 1'b1;
        #1;
        checkOutput("mid reset outputs",
                    32'({busy, init_ok, init_err, err_code, wr_count}), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        setNominal();
        applyStimulus("after reset");

        // Random write lists around the boundaries.
        for (int s = 0; s < 24; s++) begin
            nPulses = ($urandom_range(0, 3) == 0) ? 5 : 4;
            for (int i = 0; i < nPulses; i++) begin
                if (i == 4) begin
                    gapA[i] = $urandom_range(1, TB_T_W4 - 1);
                end else begin
                    mode = $urandom_range(0, 15);
                    if (mode == 0)                gapA[i] = reqOf(i) - 1;
                    else if (mode == 1)           gapA[i] = reqOf(i);
                    else if (mode == 2 && i == 0) gapA[i] = 300;
                    else                          gapA[i] = reqOf(i) + $urandom_range(0, 20);
                end
                mode = $urandom_range(0, 15);
                if (mode == 0)      widthA[i] = TB_E_MIN - 1;
                else if (mode == 1) widthA[i] = TB_E_MIN;
                else                widthA[i] = TB_E_MIN + $urandom_range(0, 4);
                if ($urandom_range(0, 15) == 0) dataA[i] = 8'($urandom);
                else                            dataA[i] = tableOf(i);
                if ($urandom_range(0, 15) == 0) toggleA[i] = $urandom_range(1, widthA[i]);
                else                            toggleA[i] = 0;
            end
            applyStimulus($sformatf("rand%0d", s));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
